// File: rtl/serial_mod_pkg.sv
// Shared constants and parameter helpers for the serial modulo checker.
// Used by serial_mod_checker and mod_add_reduce.
package serial_mod_pkg;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    localparam int MODULUS_MIN = 2;
    localparam int MODULUS_MAX = 32768;

    function automatic bit modulus_ok(input int modulus);
        return (modulus >= MODULUS_MIN) && (modulus <= MODULUS_MAX);
    endfunction

    // A zero width makes an illegal MODULUS collapse visibly at elaboration.
    function automatic int rem_width(input int modulus);
        if (!modulus_ok(modulus)) begin
            return 0;
        end
        return $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_add_reduce.sv
// (a + b + cin) mod MODULUS for a, b < MODULUS using one conditional subtract.
module mod_add_reduce
    import serial_mod_pkg::*;
#(
    parameter int MODULUS = 7,
    parameter int REM_W   = rem_width(MODULUS)
) (
    input  logic [REM_W-1:0] a,
    input  logic [REM_W-1:0] b,
    input  logic             cin,
    output logic [REM_W-1:0] y
);

    localparam logic [REM_W:0] MOD_V = (REM_W+1)'(MODULUS);

    logic [REM_W:0] sum_s;

    // Sum is below 2*MODULUS, so a single subtract fully reduces it.
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b} + {{REM_W{1'b0}}, cin};
        if (sum_s >= MOD_V) begin
            y = REM_W'(sum_s - MOD_V);
        end else begin
            y = REM_W'(sum_s);
        end
    end

endmodule

// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: running remainder of a qualified bit stream mod MODULUS.
// Define SERIAL_MOD_LSB_FIRST_EN to honour Mode and build the LSB-first weight datapath.
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter int MODULUS = 7,
    parameter int REM_W   = rem_width(MODULUS),
    parameter int CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Bit_In,
    input  logic             Bit_Valid,
    input  logic             Start,
    input  logic             Mode,
    output logic [REM_W-1:0] Remainder,
    output logic             Divisible,
    output logic             Valid_Out,
    output logic [CNT_W-1:0] Bit_Count,
    output logic             Count_Sat
);

    if (!modulus_ok(MODULUS) || (REM_W != rem_width(MODULUS))) begin : g_bad_cfg
        $error("serial_mod_checker: MODULUS out of range or REM_W overridden");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1'b1);

    logic [REM_W-1:0] rem_r;
    logic [REM_W-1:0] r0_s;
    logic [REM_W-1:0] msb_rem_s;
    logic [REM_W-1:0] rem_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] c0_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sat_r;
    logic             sat_next_s;
    logic             div_r;
    logic             valid_r;

    // Start rebases the frame so restart and first bit share one cycle.
    always_comb begin
        if (Start) begin
            r0_s = {REM_W{1'b0}};
            c0_s = {CNT_W{1'b0}};
        end else begin
            r0_s = rem_r;
            c0_s = cnt_r;
        end
        if (c0_s == CNT_MAX) begin
            cnt_next_s = CNT_MAX;
        end else begin
            cnt_next_s = c0_s + CNT_W'(1'b1);
        end
        sat_next_s = (Start ? 1'b0 : sat_r) | (cnt_next_s == CNT_MAX);
    end

    mod_add_reduce #(.MODULUS(MODULUS), .REM_W(REM_W)) u_msb_step (
        .a   (r0_s),
        .b   (r0_s),
        .cin (Bit_In),
        .y   (msb_rem_s)
    );

`ifdef SERIAL_MOD_LSB_FIRST_EN
    logic             mode_r;
    logic             mode_s;
    logic [REM_W-1:0] w_r;
    logic [REM_W-1:0] w0_s;
    logic [REM_W-1:0] w_next_s;
    logic [REM_W-1:0] lsb_add_s;
    logic [REM_W-1:0] lsb_rem_s;

    // Mode is only taken from the port on a Start accept; otherwise the frame's latched mode.
    always_comb begin
        if (Start) begin
            mode_s = Mode;
            w0_s   = REM_ONE;
        end else begin
            mode_s = mode_r;
            w0_s   = w_r;
        end
        if (Bit_In) begin
            lsb_add_s = w0_s;
        end else begin
            lsb_add_s = {REM_W{1'b0}};
        end
    end

    mod_add_reduce #(.MODULUS(MODULUS), .REM_W(REM_W)) u_lsb_step (
        .a   (r0_s),
        .b   (lsb_add_s),
        .cin (1'b0),
        .y   (lsb_rem_s)
    );

    mod_add_reduce #(.MODULUS(MODULUS), .REM_W(REM_W)) u_weight_dbl (
        .a   (w0_s),
        .b   (w0_s),
        .cin (1'b0),
        .y   (w_next_s)
    );

    // Selects the step result for the frame's mode.
    always_comb begin
        case (mode_s)
            MODE_LSB: rem_next_s = lsb_rem_s;
            default:  rem_next_s = msb_rem_s;
        endcase
    end

    // Frame mode and bit weight registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mode_r <= MODE_MSB;
            w_r    <= REM_ONE;
        end else if (Bit_Valid) begin
            mode_r <= mode_s;
            w_r    <= w_next_s;
        end else begin
            mode_r <= mode_r;
            w_r    <= w_r;
        end
    end
`else
    logic unused_mode_s;

    // MSB-first only build: Mode is deliberately ignored.
    always_comb begin
        unused_mode_s = Mode;
        rem_next_s    = msb_rem_s;
    end
`endif

    // Frame state and output registers; non-accept cycles hold everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rem_r   <= {REM_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
            div_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (Bit_Valid) begin
            rem_r   <= rem_next_s;
            cnt_r   <= cnt_next_s;
            sat_r   <= sat_next_s;
            div_r   <= (rem_next_s == {REM_W{1'b0}}) && (cnt_next_s != {CNT_W{1'b0}});
            valid_r <= 1'b1;
        end else begin
            rem_r   <= rem_r;
            cnt_r   <= cnt_r;
            sat_r   <= sat_r;
            div_r   <= div_r;
            valid_r <= 1'b0;
        end
    end

    assign Remainder = rem_r;
    assign Bit_Count = cnt_r;
    assign Count_Sat = sat_r;
    assign Divisible = div_r;
    assign Valid_Out = valid_r;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Scoreboard bench for serial_mod_checker: a frame-level arithmetic model predicts each cycle.
module tb_serial_mod_checker;

    localparam int M     = 7;
    localparam int REM_W = $clog2(M);
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             Bit_In = 1'b0;
    logic             Bit_Valid = 1'b0;
    logic             Start = 1'b0;
    logic             Mode = 1'b0;
    logic [REM_W-1:0] Remainder;
    logic             Divisible;
    logic             Valid_Out;
    logic [CNT_W-1:0] Bit_Count;
    logic             Count_Sat;

    serial_mod_checker #(.MODULUS(M), .CNT_W(CNT_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Bit_In    (Bit_In),
        .Bit_Valid (Bit_Valid),
        .Start     (Start),
        .Mode      (Mode),
        .Remainder (Remainder),
        .Divisible (Divisible),
        .Valid_Out (Valid_Out),
        .Bit_Count (Bit_Count),
        .Count_Sat (Count_Sat)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int rem;
        int div;
        int valid;
        int cnt;
        int sat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 1'b0;

`ifdef SERIAL_MOD_LSB_FIRST_EN
    localparam bit LSB_EN = 1'b1;
`else
    localparam bit LSB_EN = 1'b0;
`endif

    // Reference model: frame value tracked with plain modular arithmetic.
    int m_rem = 0, m_pow = 1, m_cnt = 0, m_sat = 0, m_lsb = 0, m_div = 0;

    task automatic apply(input bit rst, input bit v, input bit s, input bit b, input bit md);
        exp_t e;
        Reset = rst; Bit_Valid = v; Start = s; Bit_In = b; Mode = md;
        if (rst) begin
            m_rem = 0; m_pow = 1; m_cnt = 0; m_sat = 0; m_lsb = 0; m_div = 0;
            e.valid = 0;
        end else if (v) begin
            if (s) begin
                m_rem = 0; m_pow = 1; m_cnt = 0; m_sat = 0;
                m_lsb = LSB_EN ? int'(md) : 0;
            end
            if (m_lsb != 0) begin
                m_rem = (m_rem + int'(b) * m_pow) % M;
            end else begin
                m_rem = (m_rem * 2 + int'(b)) % M;
            end
            m_pow = (m_pow * 2) % M;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (m_cnt == CMAX) m_sat = 1;
            m_div = (m_rem == 0) ? 1 : 0;
            e.valid = 1;
        end else begin
            e.valid = 0;
        end
        e.rem = m_rem; e.div = m_div; e.cnt = m_cnt; e.sat = m_sat;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic send_bits(input bit first_start, input int n, input logic [31:0] bits);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b1, first_start && (i == 0), bits[n-1-i], 1'b0);
        end
    endtask

    // Monitor: each cycle's outputs are checked against the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (int'(Remainder) != e.rem || int'(Divisible) != e.div ||
                    int'(Valid_Out) != e.valid || int'(Bit_Count) != e.cnt ||
                    int'(Count_Sat) != e.sat) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got rem=%0d div=%0d vo=%0d cnt=%0d sat=%0d, want rem=%0d div=%0d vo=%0d cnt=%0d sat=%0d",
                             $time, Remainder, Divisible, Valid_Out, Bit_Count, Count_Sat,
                             e.rem, e.div, e.valid, e.cnt, e.sat);
                end
            end
        end
    end

    initial begin : stimulus
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        // Value 21 MSB-first: remainders 1,2,5,3,0.
        send_bits(1'b1, 5, 32'b10101);
        // Gap cycles between bits hold state.
        send_bits(1'b1, 2, 32'b11);
        repeat (3) apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bits(1'b0, 3, 32'b001);
        // Restart with bit 1 in the same cycle.
        send_bits(1'b0, 3, 32'b101);
        send_bits(1'b1, 1, 32'b1);
        // LSB-first request (honoured only when the feature is built).
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        // Reset mid-frame, then continue without Start.
        send_bits(1'b1, 2, 32'b11);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(1'b0, 3, 32'b111);
        // Saturation: 17 ones, then Start clears Count_Sat.
        send_bits(1'b1, 17, 32'h1FFFF);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(1'b1, 1, 32'b0);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(99) < 2), ($urandom_range(99) < 70),
                  ($urandom_range(99) < 8), 1'($urandom), 1'($urandom));
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done || ($time > 200000));
        @(negedge Clock);
        #1;
        if (!stim_done || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: pending=%0d done=%0d, want pending=0 done=1", exp_q.size(), stim_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
